// File: rtl/divider_pkg.sv
// Shared types and constants for the 16-by-8 restoring divider.
package divider_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int N_STEPS    = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CALC     = 2'b01,
        WAIT_RFD = 2'b10,
        OUT      = 2'b11
    } state_t;

endpackage

// File: rtl/divider_div_step.sv
// One restoring step: shift the partial remainder left, subtract the
// divisor from the high half when it fits, and shift in the quotient bit.
module div_step
    import divider_pkg::*;
(
    input  logic [DIVIDEND_W-1:0] i_rem,
    input  logic [DIVISOR_W-1:0]  i_div,
    output logic [DIVIDEND_W-1:0] o_rem
);

    logic [DIVISOR_W:0]   w_hi;
    logic [DIVISOR_W-1:0] w_diff;

    // High half of the 17-bit shifted value; bit 8 is the carried-out MSB.
    assign w_hi   = {i_rem[15:8], i_rem[7]};
    assign w_diff = w_hi[7:0] - i_div;

    always_comb begin
        if (w_hi >= {1'b0, i_div}) begin
            o_rem = {w_diff, i_rem[6:0], 1'b1};
        end else begin
            o_rem = {i_rem[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Sequential 16/8 restoring divider with /dav-rfd handshakes.
// Optional overflow pre-check and ovf port: define DIVIDER_OVF_EN.
module divider
    import divider_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DIVIDEND_W-1:0] data_in,
    input  logic [DIVISOR_W-1:0]  divisor_in,
    input  logic                  dav_in_,
    output logic                  rfd_in,
    output logic [DIVISOR_W-1:0]  quot_out,
    output logic [DIVISOR_W-1:0]  rem_out,
    output logic                  dav_out_,
    input  logic                  rfd_q,
    input  logic                  rfd_r
`ifdef DIVIDER_OVF_EN
    ,
    output logic                  ovf
`endif
);

    state_t                r_state;
    logic [DIVIDEND_W-1:0] r_rem;
    logic [DIVISOR_W-1:0]  r_div;
    logic [2:0]            r_count;
    logic                  r_rfd_in;
    logic                  r_dav_out_;
    logic [DIVIDEND_W-1:0] w_next_rem;

`ifdef DIVIDER_OVF_EN
    logic r_ovf;
    logic w_ovf;

    assign w_ovf = (divisor_in == '0) || (data_in[15:8] >= divisor_in);
    assign ovf   = r_ovf;
`endif

    div_step u_step (
        .i_rem (r_rem),
        .i_div (r_div),
        .o_rem (w_next_rem)
    );

    // Results live in the partial-remainder register itself.
    assign quot_out = r_rem[7:0];
    assign rem_out  = r_rem[15:8];
    assign rfd_in   = r_rfd_in;
    assign dav_out_ = r_dav_out_;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_div      <= '0;
            r_count    <= '0;
            r_rfd_in   <= 1'b1;
            r_dav_out_ <= 1'b1;
`ifdef DIVIDER_OVF_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!dav_in_) begin
                        r_rfd_in <= 1'b0;
                        r_div    <= divisor_in;
                        r_count  <= '0;
`ifdef DIVIDER_OVF_EN
                        if (w_ovf) begin
                            r_rem   <= 16'h00FF;
                            r_ovf   <= 1'b1;
                            r_state <= WAIT_RFD;
                        end else begin
                            r_rem   <= data_in;
                            r_ovf   <= 1'b0;
                            r_state <= CALC;
                        end
`else
                        r_rem   <= data_in;
                        r_state <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_rem   <= w_next_rem;
                    r_count <= r_count + 3'd1;
                    if (r_count == 3'(N_STEPS - 1)) begin
                        r_state <= WAIT_RFD;
                    end
                end
                WAIT_RFD: begin
                    if (rfd_q && rfd_r) begin
                        r_dav_out_ <= 1'b0;
                        r_state    <= OUT;
                    end
                end
                OUT: begin
                    // Held until both consumers drop and the producer releases.
                    if (!rfd_q && !rfd_r && dav_in_) begin
                        r_dav_out_ <= 1'b1;
                        r_rfd_in   <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases, random divisions
// against plain integer division, consumer skew and mid-run reset.
module tb_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [7:0]  divisor_in;
    logic        dav_in_;
    logic        rfd_in;
    logic [7:0]  quot_out;
    logic [7:0]  rem_out;
    logic        dav_out_;
    logic        rfd_q;
    logic        rfd_r;
`ifdef DIVIDER_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    divider dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .divisor_in (divisor_in),
        .dav_in_    (dav_in_),
        .rfd_in     (rfd_in),
        .quot_out   (quot_out),
        .rem_out    (rem_out),
        .dav_out_   (dav_out_),
        .rfd_q      (rfd_q),
        .rfd_r      (rfd_r)
`ifdef DIVIDER_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rfd(input string name);
        int n = 0;
        while (rfd_in !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (rfd_in !== 1'b1) begin
            bad++;
            $display("FAIL %s rfd_in wait: got=%b want=1", name, rfd_in);
        end
    endtask

    // One complete transaction; checks capture, latency, results, release.
    task automatic do_div(input logic [15:0] a, input logic [7:0] d,
                          input int exp_lat, input logic [7:0] eq,
                          input logic [7:0] er, input bit chk_r,
                          input bit exp_ovf, input string name);
        int n = 0;
        wait_rfd(name);
        data_in    = a;
        divisor_in = d;
        dav_in_    = 1'b0;
        tick();
        dav_in_    = 1'b1;
        total++;
        if (rfd_in !== 1'b0) begin
            bad++;
            $display("FAIL %s capture rfd_in: got=%b want=0", name, rfd_in);
        end
        while (dav_out_ !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n !== exp_lat) begin
            bad++;
            $display("FAIL %s latency: got=%0d want=%0d", name, n, exp_lat);
        end
        total++;
        if (quot_out !== eq) begin
            bad++;
            $display("FAIL %s quot: got=%h want=%h", name, quot_out, eq);
        end
        if (chk_r) begin
            total++;
            if (rem_out !== er) begin
                bad++;
                $display("FAIL %s rem: got=%h want=%h", name, rem_out, er);
            end
        end
`ifdef DIVIDER_OVF_EN
        total++;
        if (ovf !== exp_ovf) begin
            bad++;
            $display("FAIL %s ovf: got=%b want=%b", name, ovf, exp_ovf);
        end
`endif
        rfd_q = 1'b0;
        rfd_r = 1'b0;
        tick();
        total++;
        if (dav_out_ !== 1'b1 || rfd_in !== 1'b1) begin
            bad++;
            $display("FAIL %s release: dav_out_=%b rfd_in=%b want 1 1",
                     name, dav_out_, rfd_in);
        end
        rfd_q = 1'b1;
        rfd_r = 1'b1;
    endtask

    // Reference: plain integer division of the area by the side.
    task automatic ref_div(input string name, input logic [15:0] a,
                           input logic [7:0] d);
        int q;
        int r;
        q = int'(a) / int'(d);
        r = int'(a) % int'(d);
        do_div(a, d, 9, 8'(q), 8'(r), 1'b1, 1'b0, name);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        data_in    = '0;
        divisor_in = '0;
        dav_in_    = 1'b1;
        rfd_q      = 1'b1;
        rfd_r      = 1'b1;
        tick();
        tick();
        total++;
        if (rfd_in !== 1'b1 || dav_out_ !== 1'b1 ||
            quot_out !== 8'h00 || rem_out !== 8'h00) begin
            bad++;
            $display("FAIL reset: rfd=%b dav=%b q=%h r=%h want 1 1 00 00",
                     rfd_in, dav_out_, quot_out, rem_out);
        end
`ifdef DIVIDER_OVF_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset ovf: got=%b want=0", ovf);
        end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        ref_div("d_03e8", 16'h03E8, 8'h19);
        ref_div("d_1234", 16'h1234, 8'h56);
        ref_div("d_feff", 16'hFEFF, 8'hFF);
        ref_div("d_zero", 16'h0000, 8'h07);
        ref_div("d_one",  16'h00FF, 8'h01);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            int d;
            int a;
            d = int'($urandom_range(1, 255));
            a = int'($urandom_range(0, d * 256 - 1));
            ref_div("rand", 16'(a), 8'(d));
        end
    endtask

    task automatic test_overflow();
`ifdef DIVIDER_OVF_EN
        do_div(16'h0100, 8'h01, 1, 8'hFF, 8'h00, 1'b1, 1'b1, "ovf_big");
        do_div(16'h0005, 8'h00, 1, 8'hFF, 8'h00, 1'b1, 1'b1, "ovf_zero");
        ref_div("ovf_clear", 16'h03E8, 8'h19);
`else
        do_div(16'h0005, 8'h00, 9, 8'hFF, 8'h00, 1'b0, 1'b0, "div_zero");
`endif
    endtask

    task automatic test_skew();
        int n = 0;
        wait_rfd("skew");
        data_in    = 16'h1234;
        divisor_in = 8'h56;
        dav_in_    = 1'b0;
        while (dav_out_ !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (dav_out_ !== 1'b0 || quot_out !== 8'h36 || rem_out !== 8'h10) begin
            bad++;
            $display("FAIL skew result: dav=%b q=%h r=%h want 0 36 10",
                     dav_out_, quot_out, rem_out);
        end
        rfd_q = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (dav_out_ !== 1'b0) begin
                bad++;
                $display("FAIL skew hold %0d: dav_out_=%b want 0", i, dav_out_);
            end
        end
        rfd_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dav_out_ !== 1'b0 || rfd_in !== 1'b0) begin
                bad++;
                $display("FAIL skew producer hold %0d: dav=%b rfd=%b want 0 0",
                         i, dav_out_, rfd_in);
            end
        end
        dav_in_ = 1'b1;
        tick();
        total++;
        if (dav_out_ !== 1'b1 || rfd_in !== 1'b1) begin
            bad++;
            $display("FAIL skew release: dav=%b rfd=%b want 1 1",
                     dav_out_, rfd_in);
        end
        rfd_q = 1'b1;
        rfd_r = 1'b1;
    endtask

    task automatic test_reset_mid_calc();
        wait_rfd("mid_reset");
        data_in    = 16'h03E8;
        divisor_in = 8'h19;
        dav_in_    = 1'b0;
        tick();
        dav_in_    = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        total++;
        if (rfd_in !== 1'b1 || dav_out_ !== 1'b1 ||
            quot_out !== 8'h00 || rem_out !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset: rfd=%b dav=%b q=%h r=%h want 1 1 00 00",
                     rfd_in, dav_out_, quot_out, rem_out);
        end
        reset = 1'b0;
        tick();
        ref_div("after_reset", 16'h03E8, 8'h19);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_overflow();
        test_skew();
        test_reset_mid_calc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Sequential 16-by-8 restoring divider: the inverse of the rectangle-area multiplier. It accepts an area and one side from a single producer over a /dav-rfd handshake, and computes the other side (quotient) and remainder in 8 iterations. It delivers both results to two consumers through one shared /dav-rfd output handshake. It sits between the area path and downstream blocks that need side lengths.

## Interface
- No parameters; widths are fixed (16-bit dividend, 8-bit divisor, quotient and remainder).
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  16  dividend (area) from producer.
- divisor_in  in  8  divisor (known side) from producer.
- dav_in_  in  1  producer data valid, active low.
- rfd_in  out  1  ready for data to producer.
- quot_out  out  8  quotient, to consumer Q.
- rem_out  out  8  remainder, to consumer R.
- dav_out_  out  1  shared data valid to both consumers, active low.
- rfd_q  in  1  consumer Q ready for data.
- rfd_r  in  1  consumer R ready for data.
- ovf  out  1  overflow / divide-by-zero flag; present only with DIVIDER_OVF_EN.

## Operation
- **State machine**: IDLE, CALC, WAIT_RFD, OUT.
- **IDLE**
  - rfd_in=1.
  - On dav_in_==0: capture data_in into REM (16 bit) and divisor_in into DIV; COUNT=0; go to CALC.
- **CALC**
  - rfd_in=0. One restoring step per cycle.
  - Each step: shift REM left 1 into a 17-bit value T. If T[16:8] >= DIV, then T[16:8] -= DIV and T[0]=1. REM=T[15:0].
  - COUNT increments each step; after step 8 (COUNT==7 on the transition edge), go to WAIT_RFD.
- **Results**: quot_out=REM[7:0], rem_out=REM[15:8]. Both are valid and stable from WAIT_RFD entry through OUT exit.
- **WAIT_RFD**: rfd_in=0, dav_out_=1. Wait for rfd_q==1 and rfd_r==1, then go to OUT.
- **OUT**
  - dav_out_=0.
  - Return to IDLE only when rfd_q==0 and rfd_r==0 and dav_in_==1.
  - A producer still holding dav_in_ low keeps the block in OUT, so no datum is sampled twice.
- **Consumer skew**: if one consumer drops rfd early, dav_out_ stays low until both have dropped.
- **Widths**: no result wider than 8 bits. Overflow cases are handled under Configuration.

## Timing
- **Reset values** (on any edge with reset==1, in any state, including mid-CALC):
  - State IDLE, rfd_in=1, dav_out_=1, quot_out=0, rem_out=0, ovf=0, COUNT=0.
  - A partial result is discarded.
- All outputs are registered; no combinational path from inputs to outputs.
- **Capture**: edge k samples dav_in_==0 in IDLE; rfd_in=0 from edge k.
- **Normal latency**: CALC covers edges k+1..k+8. The earliest dav_out_ fall is after edge k+9, with consumers already ready.
- **Overflow latency** (with macro): CALC is skipped and WAIT_RFD is entered at edge k. The earliest dav_out_ fall is after edge k+1.
- **Throughput**: minimum 11 cycles per division. The limit is the handshake return path.

## Configuration
- **Macro**: DIVIDER_OVF_EN.
- **Defined**:
  - At capture, overflow = (divisor_in==0) or (data_in[15:8] >= divisor_in).
  - On overflow: quot_out=8'hFF, rem_out=8'h00, ovf=1, CALC skipped.
  - ovf is cleared at the next capture.
- **Undefined**:
  - No ovf port and no pre-check; all inputs run 8 CALC steps.
  - For overflow inputs, quot_out/rem_out are the raw REM contents and are not checked by verification.
  - Divisor 0 yields quot_out=8'hFF.

## Structure
- **Shared package divider_pkg**:
  - State encoding localparams: IDLE=2'b00, CALC=2'b01, WAIT_RFD=2'b10, OUT=2'b11.
  - Width constants: DIVIDEND_W=16, DIVISOR_W=8.
  - Step count N_STEPS=8.
- **Sub-module div_step** (combinational): inputs REM[15:0] and DIV[7:0]; output next REM[15:0]. It implements one shift/compare/subtract.
- **Top level**: data path (REM, DIV, COUNT, handshake regs) plus a 2-bit control unit.

## Test plan
- 0x03E8 / 0x19, consumers ready -> quot_out=0x28, rem_out=0x00; dav_out_ low at edge k+9.
- 0x1234 / 0x56 -> quot_out=0x36, rem_out=0x10.
- 0xFEFF / 0xFF (largest non-overflow) -> quot_out=0xFF, rem_out=0xFE, ovf=0.
- With DIVIDER_OVF_EN:
  - 0x0100 / 0x01 -> ovf=1, quot_out=0xFF, rem_out=0x00; dav_out_ low at edge k+1.
  - 0x0005 / 0x00 -> same response.
- Consumer skew: rfd_r drops 5 cycles after rfd_q -> dav_out_ stays low until rfd_r==0. Producer holding dav_in_ low blocks the return to IDLE.
- reset pulsed at CALC step 4 -> next edge: rfd_in=1, dav_out_=1, outputs 0. A fresh 0x03E8 / 0x19 then completes correctly.
